// File: rtl/debug_pkg.sv
// Shared constants, op codes, state encodings and frame builder for the
// serial debug chain root controller.
package debug_pkg;

    localparam int          SF_BITS         = 144;
    localparam logic [14:0] BROADCAST_ADDR  = 15'h7FFF;
    localparam logic        READ_DIRECTION  = 1'b0;
    localparam logic        WRITE_DIRECTION = 1'b1;
    localparam logic [7:0]  READ_CMD_IDENT  = 8'h00;

    typedef enum logic [1:0] {
        OP_ENUM  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Frame layout: [0] direction, [15:1] address, [143:16] payload.
    function automatic logic [SF_BITS-1:0] build_frame(input op_e         op,
                                                       input logic [14:0]  addr,
                                                       input logic [127:0] data);
        logic [SF_BITS-1:0] f;
        f = '0;
        case (op)
            OP_ENUM: begin
                f[15:1] = BROADCAST_ADDR;
                f[0]    = READ_DIRECTION;
            end
            OP_READ: begin
                f[23:16] = data[7:0];
                f[15:1]  = addr;
                f[0]     = READ_DIRECTION;
            end
            OP_WRITE: begin
                f[143:16] = data;
                f[15:1]   = addr;
                f[0]      = WRITE_DIRECTION;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/debug_chain_master_if.sv
// Command/response handshake between the debug host logic and the chain master.
interface debug_chain_master_if;
    import debug_pkg::*;

    logic         cmd_valid;
    logic         cmd_ready;
    op_e          cmd_op;
    logic [14:0]  cmd_addr;
    logic [127:0] cmd_data;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         rsp_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout
    );

endinterface

// File: rtl/debug_frame_rx.sv
// Return-frame receiver: synchronizes rx_clk/rx_data, waits for the first
// falling edge after arming, then shifts in one bit per rising edge.
module debug_frame_rx
    import debug_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               rx_data,
    input  logic               rx_clk,
    output logic               done,
    output logic [SF_BITS-1:0] frame
);

    localparam logic [7:0] LAST_BIT = 8'(SF_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   armed_q, armed_d;
    logic                   started_q, started_d;
    logic                   done_q, done_d;
    logic [7:0]             count_q, count_d;
    logic [SF_BITS-1:0]     shreg_q, shreg_d;
    logic                   clk_s, data_s, fall, rise;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;
    assign rise   = ~clk_prev_q & clk_s;

    always_comb begin
        armed_d   = armed_q;
        started_d = started_q;
        done_d    = done_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        if (arm) begin
            armed_d   = 1'b1;
            started_d = 1'b0;
            done_d    = 1'b0;
            count_d   = 8'd0;
        end else if (armed_q && !started_q && fall) begin
            started_d = 1'b1;
        end else if (started_q && rise) begin
            shreg_d = {shreg_q[SF_BITS-2:0], data_s};
            count_d = count_q + 8'd1;
            if (count_q == LAST_BIT) begin
                done_d    = 1'b1;
                armed_d   = 1'b0;
                started_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            started_q   <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], rx_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], rx_data};
            clk_prev_q  <= clk_s;
            armed_q     <= armed_d;
            started_q   <= started_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    // Capture register is pure data; the done flag qualifies it.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign done  = done_q;
    assign frame = shreg_q;

endmodule

// File: rtl/debug_chain_master.sv
// Root controller of the looped serial debug chain: serializes one 144-bit
// command frame per request and reports the frame that comes back.
module debug_chain_master
    import debug_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000,
    parameter int          SYNC_STAGES    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           prescaler,
    debug_chain_master_if.slave  bus,
    output logic [14:0]          node_count,
    output logic                 enumerated,
    output logic                 tx_data,
    output logic                 tx_clk,
    input  logic                 rx_data,
    input  logic                 rx_clk
);

    localparam logic [7:0] LAST_BIT = 8'(SF_BITS - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [7:0]         p_q, p_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         bit_q, bit_d;
    logic [31:0]        tmo_q, tmo_d;
    logic [SF_BITS-1:0] frame_q, frame_d;
    logic               tx_clk_q, tx_clk_d;
    logic               tx_data_q, tx_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [127:0]       rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [14:0]        node_count_q, node_count_d;
    logic               enumerated_q, enumerated_d;
    logic               arm, reject;
    logic               rx_done;
    logic [SF_BITS-1:0] rx_frame;

    // Half-period below 2 clocks would starve the node-side synchronizers.
    function automatic logic [7:0] clamp_prescaler(input logic [7:0] p);
        return (p < 8'd2) ? 8'd2 : p;
    endfunction

    assign reject = (bus.cmd_op == OP_RSVD) ||
                    ((bus.cmd_op != OP_ENUM) &&
                     (!enumerated_q || (bus.cmd_addr >= node_count_q)));

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        p_d           = p_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        tmo_d         = tmo_q;
        frame_d       = frame_q;
        tx_clk_d      = tx_clk_q;
        tx_data_d     = tx_data_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        node_count_d  = node_count_q;
        enumerated_d  = enumerated_q;
        arm           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (reject) begin
                        state_d       = ST_DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_data_d    = '0;
                    end else begin
                        state_d  = ST_PRE;
                        op_d     = bus.cmd_op;
                        p_d      = clamp_prescaler(prescaler);
                        frame_d  = build_frame(bus.cmd_op, bus.cmd_addr, bus.cmd_data);
                        cnt_d    = 8'd0;
                        tx_clk_d = 1'b1;
                        arm      = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == p_q - 8'd1) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = 8'd0;
                    bit_d     = 8'd0;
                    tx_clk_d  = 1'b0;
                    tx_data_d = frame_q[SF_BITS-1];
                    frame_d   = {frame_q[SF_BITS-2:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != p_q - 8'd1) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (!tx_clk_q) begin
                        tx_clk_d = 1'b1;
                    end else if (bit_q == LAST_BIT) begin
                        state_d = ST_WAIT;
                        tmo_d   = 32'd0;
                    end else begin
                        tx_clk_d  = 1'b0;
                        tx_data_d = frame_q[SF_BITS-1];
                        frame_d   = {frame_q[SF_BITS-2:0], 1'b0};
                        bit_d     = bit_q + 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (rx_done) begin
                    state_d       = ST_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = rx_frame[SF_BITS-1:16];
                    if (op_q == OP_ENUM) begin
                        node_count_d = rx_frame[30:16];
                        enumerated_d = 1'b1;
                    end
                end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d       = ST_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = '0;
                    if (op_q == OP_ENUM) enumerated_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_ENUM;
            p_q           <= 8'd2;
            cnt_q         <= 8'd0;
            bit_q         <= 8'd0;
            tmo_q         <= 32'd0;
            tx_clk_q      <= 1'b1;
            tx_data_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            node_count_q  <= 15'd0;
            enumerated_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            p_q           <= p_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            tmo_q         <= tmo_d;
            tx_clk_q      <= tx_clk_d;
            tx_data_q     <= tx_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            node_count_q  <= node_count_d;
            enumerated_q  <= enumerated_d;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    debug_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .rx_data (rx_data),
        .rx_clk  (rx_clk),
        .done    (rx_done),
        .frame   (rx_frame)
    );

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign node_count      = node_count_q;
    assign enumerated      = enumerated_q;
    assign tx_clk          = tx_clk_q;
    assign tx_data         = tx_data_q;

endmodule

// File: tb/tb_debug_chain_master.sv
// Directed bench for debug_chain_master: loopback, scripted chain replies,
// rejections, timeouts and asynchronous reset mid-frame.
module tb_debug_chain_master;
    import debug_pkg::*;

    localparam int BUDGET = 4000;

    typedef struct {
        op_e          op;
        logic [14:0]  addr;
        logic [127:0] data;
        logic [7:0]   presc;
        int           mode;       // 0 loopback, 1 scripted reply, 2 silent
        logic [143:0] resp;
        logic         exp_err;
        logic         exp_tmo;
        logic [127:0] exp_rsp;
        logic [143:0] exp_frame;
        logic [14:0]  exp_nc;
        logic         exp_en;
        int           exp_lat;    // -1: latency not fixed
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] prescaler = 8'd2;
    logic       tx_data, tx_clk, rx_data, rx_clk;
    logic [14:0] node_count;
    logic       enumerated;
    logic       r_clk = 1'b1;
    logic       r_data = 1'b0;
    int         mode = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    localparam logic [127:0] DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    localparam logic [127:0] ID1  = 128'h5345_5249_414C_4442_4700_0000_0000_0001;
    localparam logic [127:0] OUT1 = 128'h0000_0000_0000_0000_0000_0000_CAFE_0005;
    localparam logic [127:0] XW   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [143:0] F_ENUM = {128'd0, 15'h7FFF, 1'b0};

    debug_chain_master_if bus();

    assign rx_clk  = (mode == 0) ? tx_clk  : ((mode == 1) ? r_clk  : 1'b1);
    assign rx_data = (mode == 0) ? tx_data : ((mode == 1) ? r_data : 1'b0);

    debug_chain_master #(
        .TIMEOUT_CYCLES (32'd1000),
        .SYNC_STAGES    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prescaler  (prescaler),
        .bus        (bus),
        .node_count (node_count),
        .enumerated (enumerated),
        .tx_data    (tx_data),
        .tx_clk     (tx_clk),
        .rx_data    (rx_data),
        .rx_clk     (rx_clk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [143:0] cap;
        logic [127:0] g_data;
        logic         g_err, g_tmo, prev_tx, r_on;
        int           capn, edges, lat, r_bit, r_ph;
        string        tag;
        tag = $sformatf("v%0d", idx);
        mode = v.mode;
        r_clk = 1'b1;
        r_data = 1'b0;
        check({tag, "_ready"}, 144'(bus.cmd_ready), 144'(1'b1));
        bus.cmd_op    = v.op;
        bus.cmd_addr  = v.addr;
        bus.cmd_data  = v.data;
        prescaler     = v.presc;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        cap = '0; capn = 0; edges = 0; lat = -1; prev_tx = 1'b1;
        r_on = 1'b0; r_bit = 0; r_ph = 0;
        g_data = '0; g_err = 1'b0; g_tmo = 1'b0;
        for (int n = 0; n <= BUDGET && lat < 0; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (tx_clk !== prev_tx) edges++;
            if (!prev_tx && tx_clk && capn < 144) begin
                cap = {cap[142:0], tx_data};
                capn++;
            end
            prev_tx = tx_clk;
            if (bus.rsp_valid) begin
                lat = n; g_data = bus.rsp_data; g_err = bus.rsp_err; g_tmo = bus.rsp_timeout;
            end
            if (v.mode == 1) begin
                if (capn == 144) r_on = 1'b1;
                if (r_on && r_bit < 144) begin
                    if (r_ph == 0) begin
                        r_clk = 1'b0;
                        r_data = v.resp[143 - r_bit];
                    end else if (r_ph == 3) begin
                        r_clk = 1'b1;
                    end
                    if (r_ph == 5) begin
                        r_ph = 0;
                        r_bit++;
                    end else begin
                        r_ph++;
                    end
                end
            end
        end
        n_cmp++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL %s_rsp_seen: no rsp_valid within %0d cycles", tag, BUDGET);
        end
        if (v.exp_lat >= 0) check_int({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_err"}, 144'(g_err), 144'(v.exp_err));
        check({tag, "_timeout"}, 144'(g_tmo), 144'(v.exp_tmo));
        check({tag, "_rsp_data"}, 144'(g_data), 144'(v.exp_rsp));
        if (v.exp_err) begin
            check_int({tag, "_tx_edges"}, edges, 0);
        end else begin
            check_int({tag, "_tx_bits"}, capn, 144);
            check({tag, "_frame"}, cap, v.exp_frame);
        end
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 144'(bus.rsp_valid), 144'(1'b0));
        check({tag, "_ready_after"}, 144'(bus.cmd_ready), 144'(1'b1));
        check({tag, "_txclk_idle"}, 144'(tx_clk), 144'(1'b1));
        check({tag, "_node_count"}, 144'(node_count), 144'(v.exp_nc));
        check({tag, "_enumerated"}, 144'(enumerated), 144'(v.exp_en));
    endtask

    function automatic vec_t mk(input op_e op, input logic [14:0] addr, input logic [127:0] data,
                                input logic [7:0] presc, input int md, input logic [143:0] resp,
                                input logic err, input logic tmo, input logic [127:0] rsp,
                                input logic [143:0] frame, input logic [14:0] nc, input logic en,
                                input int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.presc = presc; v.mode = md; v.resp = resp;
        v.exp_err = err; v.exp_tmo = tmo; v.exp_rsp = rsp; v.exp_frame = frame;
        v.exp_nc = nc; v.exp_en = en; v.exp_lat = lat;
        return v;
    endfunction

    vec_t vecs[11];
    vec_t post;

    initial begin
        vecs[0]  = mk(OP_READ,  15'd0, 128'd0, 8'd2, 0, 144'd0, 1'b1, 1'b0, 128'd0, 144'd0, 15'd0, 1'b0, 0);
        vecs[1]  = mk(OP_ENUM,  15'd9, 128'd0, 8'd2, 0, 144'd0, 1'b0, 1'b0, 128'd0, F_ENUM, 15'd0, 1'b1, -1);
        vecs[2]  = mk(OP_ENUM,  15'd0, 128'd0, 8'd0, 1, {113'd0, 15'd3, 15'h7FFF, 1'b0},
                      1'b0, 1'b0, 128'd3, F_ENUM, 15'd3, 1'b1, -1);
        vecs[3]  = mk(OP_READ,  15'd1, {120'd12345, 8'h00}, 8'd5, 1, {ID1, 15'd1, 1'b0},
                      1'b0, 1'b0, ID1, {120'd0, 8'h00, 15'd1, 1'b0}, 15'd3, 1'b1, -1);
        vecs[4]  = mk(OP_READ,  15'd1, {120'd777, 8'h05}, 8'd3, 1, {OUT1, 15'd1, 1'b0},
                      1'b0, 1'b0, OUT1, {120'd0, 8'h05, 15'd1, 1'b0}, 15'd3, 1'b1, -1);
        vecs[5]  = mk(OP_WRITE, 15'd2, DATA, 8'd2, 1, {DATA, 15'd2, 1'b1},
                      1'b0, 1'b0, DATA, {DATA, 15'd2, 1'b1}, 15'd3, 1'b1, -1);
        vecs[6]  = mk(OP_READ,  15'd5, 128'd0, 8'd2, 1, 144'd0, 1'b1, 1'b0, 128'd0, 144'd0, 15'd3, 1'b1, 0);
        vecs[7]  = mk(OP_RSVD,  15'd0, 128'd0, 8'd2, 0, 144'd0, 1'b1, 1'b0, 128'd0, 144'd0, 15'd3, 1'b1, 0);
        vecs[8]  = mk(OP_WRITE, 15'd3, DATA, 8'd2, 0, 144'd0, 1'b1, 1'b0, 128'd0, 144'd0, 15'd3, 1'b1, 0);
        vecs[9]  = mk(OP_WRITE, 15'd0, XW, 8'd2, 2, 144'd0, 1'b0, 1'b1, 128'd0, {XW, 15'd0, 1'b1},
                      15'd3, 1'b1, 289 * 2 + 1000);
        vecs[10] = mk(OP_ENUM,  15'd0, 128'd0, 8'd3, 2, 144'd0, 1'b0, 1'b1, 128'd0, F_ENUM,
                      15'd3, 1'b0, 289 * 3 + 1000);
        post     = mk(OP_ENUM,  15'd0, 128'd0, 8'd4, 0, 144'd0, 1'b0, 1'b0, 128'd0, F_ENUM, 15'd0, 1'b1, -1);

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_ENUM;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 144'(bus.cmd_ready), 144'(1'b1));
        check("rst_txclk", 144'(tx_clk), 144'(1'b1));
        check("rst_txdata", 144'(tx_data), 144'(1'b0));
        check("rst_rsp_valid", 144'(bus.rsp_valid), 144'(1'b0));
        check("rst_rsp_data", 144'(bus.rsp_data), 144'(0));
        check("rst_flags", 144'({bus.rsp_err, bus.rsp_timeout}), 144'(0));
        check("rst_node_count", 144'(node_count), 144'(0));
        check("rst_enumerated", 144'(enumerated), 144'(1'b0));

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset while shifting: after 42 clocks with P=2 tx_clk sits in a low phase.
        mode = 0;
        prescaler = 8'd2;
        bus.cmd_op = OP_ENUM;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (42) @(posedge clk);
        #1;
        check("mid_shift_txclk_low", 144'(tx_clk), 144'(1'b0));
        check("mid_shift_busy", 144'(bus.cmd_ready), 144'(1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_txclk", 144'(tx_clk), 144'(1'b1));
        check("async_rst_ready", 144'(bus.cmd_ready), 144'(1'b1));
        check("async_rst_node_count", 144'(node_count), 144'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec(post, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
